div_share_arbiter: RTL and testbench

- Shares one iterative signed 32-bit divider core among NUM_REQ requesters.
- Round-robin arbitration with a valid/ready request handshake per requester.
- Sequences the core through a start/done handshake and returns results to the owning requester over a held response handshake.
- Handles divide-by-zero locally without starting the core; includes a watchdog against a hung core.

---
 rtl/div_share_arbiter_if.sv | 26 ++
 rtl/div_share_arbiter.sv | 132 +++++++++++++
 tb/tb_div_share_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_share_arbiter_if.sv
// Requester-side bundle for div_share_arbiter: per-requester request/response
// handshakes plus the shared response data bus.
interface div_share_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_dividend;
  logic [32*NUM_REQ-1:0] req_divisor;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [NUM_REQ-1:0]    resp_ready;
  logic [31:0]           resp_quotient;
  logic [31:0]           resp_remainder;
  logic                  resp_dbz;
  logic                  resp_err;

  modport master (
    output req_valid, req_dividend, req_divisor, resp_ready,
    input  req_ready, resp_valid, resp_quotient, resp_remainder, resp_dbz, resp_err
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, resp_ready,
    output req_ready, resp_valid, resp_quotient, resp_remainder, resp_dbz, resp_err
  );
endinterface

// File: rtl/div_share_arbiter.sv
// Round-robin sharing of one iterative signed divider core among NUM_REQ
// requesters, with local divide-by-zero handling and a hung-core watchdog.
module div_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  div_share_arbiter_if.slave bus,
  output logic               div_start,
  output logic [31:0]        div_dividend,
  output logic [31:0]        div_divisor,
  input  logic               div_done,
  input  logic [31:0]        div_quotient,
  input  logic [31:0]        div_remainder,
  output logic               busy,
  output logic [ID_W-1:0]    owner
);
  // state | meaning
  // IDLE  | arbitrating; req_ready one-hot at the round-robin grant
  // ISSUE | one-cycle div_start pulse; watchdog loaded
  // WAIT  | waiting for div_done or watchdog expiry
  // RESP  | response held for the owner until resp_ready[owner]

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_nx;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_vld;
  logic             accept;
  logic [31:0]      grant_a, grant_b;
  logic [31:0]      op_a, op_b;
  logic [31:0]      res_q, res_r;
  logic             dbz, err;
  logic [CNT_W-1:0] wd_cnt;
  logic             wd_expired;

  // Searching downward lets the lowest offset from rr_ptr win the last write.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign grant_a    = bus.req_dividend[32*grant_idx +: 32];
  assign grant_b    = bus.req_divisor[32*grant_idx +: 32];
  assign accept     = rst && (state == IDLE) && grant_vld;
  assign wd_expired = (wd_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = (grant_b == '0) ? RESP : ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (div_done || wd_expired) state_nx = RESP;
      RESP:    if (bus.resp_ready[owner]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
      owner  <= '0;
      op_a   <= '0;
      op_b   <= '0;
      res_q  <= '0;
      res_r  <= '0;
      dbz    <= 1'b0;
      err    <= 1'b0;
      wd_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          owner  <= grant_idx;
          rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          op_a   <= grant_a;
          op_b   <= grant_b;
          if (grant_b == '0) begin
            res_q <= '1;
            res_r <= grant_a;
            dbz   <= 1'b1;
          end
        end
        ISSUE: wd_cnt <= CNT_W'(TIMEOUT - 1);
        WAIT: begin
          // A done arriving on the expiry cycle still yields a normal result.
          if (div_done) begin
            res_q <= div_quotient;
            res_r <= div_remainder;
          end else if (wd_expired) begin
            res_q <= '0;
            res_r <= '0;
            err   <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt - 1'b1;
          end
        end
        RESP: if (bus.resp_ready[owner]) begin
          dbz <= 1'b0;
          err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready      = accept ? (NUM_REQ'(1) << grant_idx) : '0;
  assign bus.resp_valid     = (state == RESP) ? (NUM_REQ'(1) << owner) : '0;
  assign bus.resp_quotient  = res_q;
  assign bus.resp_remainder = res_r;
  assign bus.resp_dbz       = dbz;
  assign bus.resp_err       = err;
  assign div_start          = (state == ISSUE);
  assign div_dividend       = op_a;
  assign div_divisor        = op_b;
  assign busy               = (state != IDLE);
endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: transaction-level model checked every cycle,
// a simple divider core model, and directed scenarios with literal results.
module tb_div_share_arbiter;
  localparam int NR  = 4;
  localparam int IDW = 2;
  localparam int TO  = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  div_share_arbiter_if #(.NUM_REQ(NR)) bus ();
  logic            div_start, div_done;
  logic [31:0]     div_dividend, div_divisor, div_quotient, div_remainder;
  logic            busy;
  logic [IDW-1:0]  owner;

  div_share_arbiter #(.NUM_REQ(NR), .ID_W(IDW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .busy(busy), .owner(owner)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_starts = 0;
  int last_start = -1;
  int last_done = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] v, input int rr);
    for (int k = 0; k < NR; k++)
      if (v[(rr + k) % NR]) return (rr + k) % NR;
    return -1;
  endfunction

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return {32'hDEAD_BEEF, a};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    return {32'($signed(a) / $signed(b)), 32'($signed(a) % $signed(b))};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Transaction model: phase 0 arbitrating, 1 start cycle, 2 core busy, 3 response held.
  int          m_ph = 0, m_rr = 0, m_own = 0, m_wait = 0;
  logic [31:0] m_a = '0, m_b = '0, m_q = '0, m_r = '0;
  logic        m_dbz = 1'b0, m_err = 1'b0;

  initial begin
    int g;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_ph = 0; m_rr = 0; m_own = 0; m_wait = 0;
        m_a = '0; m_b = '0; m_q = '0; m_r = '0; m_dbz = 1'b0; m_err = 1'b0;
      end else begin
        case (m_ph)
          0: begin
            g = pick(bus.req_valid, m_rr);
            if (g >= 0) begin
              m_own = g;
              m_rr  = (g + 1) % NR;
              m_a   = bus.req_dividend[32*g +: 32];
              m_b   = bus.req_divisor[32*g +: 32];
              if (m_b == 32'h0) begin
                m_q = 32'hFFFF_FFFF; m_r = m_a; m_dbz = 1'b1; m_ph = 3;
              end else m_ph = 1;
            end
          end
          1: begin m_ph = 2; m_wait = 0; end
          2: if (div_done) begin
            m_q = div_quotient; m_r = div_remainder; m_ph = 3;
          end else begin
            m_wait++;
            if (m_wait == TO) begin m_q = '0; m_r = '0; m_err = 1'b1; m_ph = 3; end
          end
          3: if (bus.resp_ready[m_own]) begin m_ph = 0; m_dbz = 1'b0; m_err = 1'b0; end
          default: m_ph = 0;
        endcase
      end
    end
  end

  initial begin
    int g2;
    forever begin
      @(negedge clk);
      g2 = (rst && m_ph == 0) ? pick(bus.req_valid, m_rr) : -1;
      chk("req_ready", 32'(bus.req_ready), (g2 >= 0) ? (32'(1) << g2) : 32'(0));
      chk("div_start", 32'(div_start), 32'(m_ph == 1));
      chk("busy", 32'(busy), 32'(m_ph != 0));
      chk("owner", 32'(owner), 32'(m_own));
      chk("resp_valid", 32'(bus.resp_valid), (m_ph == 3) ? (32'(1) << m_own) : 32'(0));
      chk("resp_dbz", 32'(bus.resp_dbz), 32'(m_dbz));
      chk("resp_err", 32'(bus.resp_err), 32'(m_err));
      if (m_ph == 3) begin
        chk("resp_quotient", bus.resp_quotient, m_q);
        chk("resp_remainder", bus.resp_remainder, m_r);
      end
      if (m_ph == 1 || m_ph == 2) begin
        chk("div_dividend", div_dividend, m_a);
        chk("div_divisor", div_divisor, m_b);
      end
      if (div_start) begin n_starts++; last_start = cyc; end
    end
  end

  // Divider core model: done pulse core_lat cycles after the start cycle.
  int          core_lat = 3;
  bit          core_hang = 1'b0;
  bit          force_done = 1'b0;
  int          core_cnt = 0;
  logic [31:0] ca = '0, cb = '0;

  initial begin
    logic [63:0] qr;
    div_done = 1'b0; div_quotient = '0; div_remainder = '0;
    forever begin
      @(posedge clk);
      #1;
      div_done = 1'b0;
      div_quotient = $urandom;
      div_remainder = $urandom;
      if (!rst) core_cnt = 0;
      else begin
        if (core_cnt > 0) begin
          core_cnt--;
          if (core_cnt == 0) begin
            qr = ref_div(ca, cb);
            div_done = 1'b1; div_quotient = qr[63:32]; div_remainder = qr[31:0];
            last_done = cyc;
          end
        end
        if (div_start && !core_hang) begin ca = div_dividend; cb = div_divisor; core_cnt = core_lat; end
      end
      if (force_done) begin div_done = 1'b1; force_done = 1'b0; end
    end
  end

  task automatic send(input int i, input logic [31:0] a, input logic [31:0] b, output int t_acc);
    bit got = 1'b0;
    bus.req_dividend[32*i +: 32] = a;
    bus.req_divisor[32*i +: 32]  = b;
    bus.req_valid[i] = 1'b1;
    for (int k = 0; k < 300 && !got; k++) begin
      #1;
      if (bus.req_ready[i]) got = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.req_valid[i] = 1'b0;
    t_acc = cyc;
    chk("accepted", 32'(got), 32'(1));
  endtask

  task automatic get_resp(input int i, output logic [31:0] q, output logic [31:0] r,
                          output logic fd, output logic fe, output int t_rv);
    bit got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      if (bus.resp_valid[i]) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("resp_seen", 32'(got), 32'(1));
    q = bus.resp_quotient; r = bus.resp_remainder; fd = bus.resp_dbz; fe = bus.resp_err;
    t_rv = cyc;
    bus.resp_ready[i] = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready[i] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 500 && busy; k++) begin @(posedge clk); #1; end
    chk("idle", 32'(busy), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench still running at %0t", $time);
    $fatal(1, "bench did not reach its end");
  end

  initial begin
    int ta, tr, s0, n, idx;
    int order[5];
    logic [31:0] q, r;
    logic fd, fe;
    bus.req_valid = '0; bus.req_dividend = '0; bus.req_divisor = '0; bus.resp_ready = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_div_start", 32'(div_start), 32'(0));
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'(0));
    chk("rst_owner", 32'(owner), 32'(0));
    chk("rst_quotient", bus.resp_quotient, 32'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;

    // All four requesters held valid: grants must rotate 0,1,2,3,0.
    core_lat = 3;
    bus.resp_ready = '1;
    bus.req_dividend = {32'hFFFF_FFF7, 32'd17, 32'd1000, 32'hFFFF_FC18};
    bus.req_divisor  = {32'hFFFF_FFFC, 32'd5, 32'hFFFF_FFF9, 32'd3};
    bus.req_valid = '1;
    for (int j = 0; j < 5; j++) order[j] = -1;
    n = 0;
    for (int k = 0; k < 3000 && n < 5; k++) begin
      #1;
      if (|bus.req_ready) begin
        idx = -1;
        for (int j = 0; j < NR; j++) if (bus.req_ready[j]) idx = j;
        order[n] = idx;
        n++;
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = '0;
    chk("grant_0", 32'(order[0]), 32'(0));
    chk("grant_1", 32'(order[1]), 32'(1));
    chk("grant_2", 32'(order[2]), 32'(2));
    chk("grant_3", 32'(order[3]), 32'(3));
    chk("grant_4", 32'(order[4]), 32'(0));
    wait_idle();
    bus.resp_ready = '0;

    // Single request, 33-cycle core.
    s0 = n_starts;
    core_lat = 33;
    send(2, 32'd100, 32'hFFFF_FFF9, ta);
    get_resp(2, q, r, fd, fe, tr);
    chk("t2_quotient", q, 32'hFFFF_FFF2);
    chk("t2_remainder", r, 32'd2);
    chk("t2_flags", {30'b0, fd, fe}, 32'(0));
    chk("t2_starts", 32'(n_starts - s0), 32'(1));
    chk("t2_start_cycle", 32'(last_start), 32'(ta));
    chk("t2_resp_after_done", 32'(tr), 32'(last_done + 1));
    chk("t2_latency", 32'(tr - ta), 32'(34));

    // Divide by zero: answered locally one cycle after acceptance.
    s0 = n_starts;
    send(1, 32'd55, 32'd0, ta);
    get_resp(1, q, r, fd, fe, tr);
    chk("dbz_quotient", q, 32'hFFFF_FFFF);
    chk("dbz_remainder", r, 32'd55);
    chk("dbz_flag", 32'(fd), 32'(1));
    chk("dbz_no_start", 32'(n_starts - s0), 32'(0));
    chk("dbz_latency", 32'(tr - ta), 32'(0));

    // Hung core: watchdog answer after 64 wait cycles, then normal service.
    core_hang = 1'b1;
    send(0, 32'd12345, 32'd3, ta);
    get_resp(0, q, r, fd, fe, tr);
    core_hang = 1'b0;
    chk("wd_err", 32'(fe), 32'(1));
    chk("wd_quotient", q, 32'(0));
    chk("wd_remainder", r, 32'(0));
    chk("wd_latency", 32'(tr - ta), 32'(65));
    core_lat = 5;
    send(3, 32'd7, 32'd2, ta);
    get_resp(3, q, r, fd, fe, tr);
    chk("post_wd_quotient", q, 32'd3);
    chk("post_wd_remainder", r, 32'd1);
    chk("post_wd_err", 32'(fe), 32'(0));

    // Done on the expiry cycle wins; done one cycle later is too late.
    core_lat = 64;
    send(1, 32'hFFFF_FFCE, 32'd7, ta);
    get_resp(1, q, r, fd, fe, tr);
    chk("edge_quotient", q, 32'hFFFF_FFF9);
    chk("edge_remainder", r, 32'hFFFF_FFFF);
    chk("edge_err", 32'(fe), 32'(0));
    core_lat = 65;
    send(2, 32'd9, 32'd3, ta);
    get_resp(2, q, r, fd, fe, tr);
    chk("late_err", 32'(fe), 32'(1));
    chk("late_quotient", q, 32'(0));
    chk("late_latency", 32'(tr - ta), 32'(65));

    // Owner withholds resp_ready while non-owners pulse theirs.
    core_lat = 4;
    send(2, 32'h8000_0000, 32'hFFFF_FFFF, ta);
    for (int k = 0; k < 200 && !bus.resp_valid[2]; k++) begin @(posedge clk); #1; end
    for (int k = 0; k < 10; k++) begin
      bus.resp_ready = NR'($urandom) & 4'b1011;
      @(posedge clk);
      #1;
      chk("stall_valid", 32'(bus.resp_valid), 32'h4);
      chk("stall_quotient", bus.resp_quotient, 32'h8000_0000);
      chk("stall_remainder", bus.resp_remainder, 32'h0);
    end
    bus.resp_ready = '0;
    get_resp(2, q, r, fd, fe, tr);

    // Reset while the core is working.
    core_lat = 33;
    send(2, 32'd100, 32'd5, ta);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_resp_valid", 32'(bus.resp_valid), 32'(0));
    chk("mid_rst_owner", 32'(owner), 32'(0));
    chk("mid_rst_operand", div_dividend, 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    force_done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("stale_done_ignored", 32'(busy), 32'(0));
    core_lat = 2;
    bus.req_dividend[32*3 +: 32] = 32'hFFFF_FFEC;
    bus.req_divisor[32*3 +: 32]  = 32'd6;
    bus.req_valid[3] = 1'b1;
    send(1, 32'd40, 32'd8, ta);
    chk("post_rst_first_owner", 32'(owner), 32'(1));
    get_resp(1, q, r, fd, fe, tr);
    chk("post_rst_q1", q, 32'd5);
    send(3, 32'hFFFF_FFEC, 32'd6, ta);
    get_resp(3, q, r, fd, fe, tr);
    chk("post_rst_q3", q, 32'hFFFF_FFFD);
    chk("post_rst_r3", r, 32'hFFFF_FFFE);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
